// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 controller read-return path:
// command word layout, burst lengths and the pending-tag entry format.
package ddr3_pkg;

  localparam int RD_BIT    = 35;
  localparam int BC4_BIT   = 34;
  localparam int TAG_MSB   = 27;
  localparam int TAG_LSB   = 0;
  localparam int TAG_W     = 28;
  localparam int BEATS_BL8 = 4;
  localparam int BEATS_BC4 = 2;

  typedef struct packed {
    logic             bc4;
    logic [TAG_W-1:0] tag;
  } tag_ent_t;

  // Index of the beat that closes a burst of the given kind.
  function automatic logic [1:0] last_beat_idx(input logic bc4);
    logic [1:0] idx;
    if (bc4) begin
      idx = 2'(BEATS_BC4 - 1);
    end else begin
      idx = 2'(BEATS_BL8 - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ddr3_rr_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module ddr3_rr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [W-1:0] mem_r [DEPTH];
  logic         wr_en_s;
  logic         rd_en_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_en_s = pop & ~empty;
  assign wr_en_s = push & (~full | rd_en_s);
  assign dout    = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update; storage is cleared so outputs read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/ddr3_rd_return.sv
// Read-return stage: queues tags from the delayed command word, assembles
// PHY read beats into bursts and hands them to the client with their tag.
import ddr3_pkg::*;

module ddr3_rd_return #(
  parameter int DW        = 64,
  parameter int TAG_DEPTH = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [35:0]       cmd_word,
  input  logic              phy_rd_valid,
  input  logic [DW-1:0]     phy_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [4*DW-1:0]   rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_bc4,
  output logic              err_orphan,
  output logic              err_tag_ovf,
  output logic              err_out_ovf,
  output logic              busy
);

  localparam int TW = $bits(tag_ent_t);
  localparam int OW = 4*DW + TAG_W + 1;

  tag_ent_t         tag_din_s;
  tag_ent_t         tag_head_s;
  logic             tag_push_s, tag_pop_s, tag_full_s, tag_empty_s;
  logic [OW-1:0]    out_din_s, out_dout_s;
  logic             out_push_s, out_pop_s, out_full_s, out_empty_s;
  logic [1:0]       cnt_r, cnt_nxt_s;
  logic [DW-1:0]    slot_r [BEATS_BL8];
  logic             beat_ok_s, complete_s;
  logic [4*DW-1:0]  burst_s;
  logic             err_orphan_r, err_tag_ovf_r, err_out_ovf_r;
  logic             unused_rsvd_s;

  assign unused_rsvd_s = ^cmd_word[33:28];
  assign tag_din_s     = '{bc4: cmd_word[BC4_BIT], tag: cmd_word[TAG_MSB:TAG_LSB]};
  assign tag_push_s    = cmd_word[RD_BIT];
  assign tag_pop_s     = complete_s;
  assign out_push_s    = complete_s;
  assign out_pop_s     = ~out_empty_s & rsp_ready;
  assign out_din_s     = {burst_s, tag_head_s.tag, tag_head_s.bc4};

  ddr3_rr_fifo #(.W(TW), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push_s),
    .din   (tag_din_s),
    .pop   (tag_pop_s),
    .dout  (tag_head_s),
    .full  (tag_full_s),
    .empty (tag_empty_s)
  );

  ddr3_rr_fifo #(.W(OW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (out_push_s),
    .din   (out_din_s),
    .pop   (out_pop_s),
    .dout  (out_dout_s),
    .full  (out_full_s),
    .empty (out_empty_s)
  );

  // Beat acceptance, burst completion and the completed burst image (closing beat bypassed in).
  always_comb begin
    beat_ok_s  = phy_rd_valid & ~tag_empty_s;
    complete_s = beat_ok_s & (cnt_r == last_beat_idx(tag_head_s.bc4));
    burst_s    = '0;
    for (int k = 0; k < BEATS_BL8; k++) begin
      if (2'(k) < cnt_r) begin
        burst_s[k*DW +: DW] = slot_r[k];
      end else if (2'(k) == cnt_r) begin
        burst_s[k*DW +: DW] = phy_rd_data;
      end else begin
        burst_s[k*DW +: DW] = '0;
      end
    end
    if (complete_s) begin
      cnt_nxt_s = 2'd0;
    end else if (beat_ok_s) begin
      cnt_nxt_s = cnt_r + 2'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Assembly slots, beat counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= 2'd0;
      err_orphan_r  <= 1'b0;
      err_tag_ovf_r <= 1'b0;
      err_out_ovf_r <= 1'b0;
      for (int k = 0; k < BEATS_BL8; k++) begin
        slot_r[k] <= '0;
      end
    end else begin
      cnt_r <= cnt_nxt_s;
      if (beat_ok_s) begin
        slot_r[cnt_r] <= phy_rd_data;
      end
      err_orphan_r  <= err_orphan_r  | (phy_rd_valid & tag_empty_s);
      err_tag_ovf_r <= err_tag_ovf_r | (tag_push_s & tag_full_s & ~tag_pop_s);
      err_out_ovf_r <= err_out_ovf_r | (complete_s & out_full_s & ~out_pop_s);
    end
  end

  assign rsp_valid   = ~out_empty_s;
  assign rsp_data    = out_dout_s[OW-1 -: 4*DW];
  assign rsp_tag     = out_dout_s[TAG_W:1];
  assign rsp_bc4     = out_dout_s[0];
  assign err_orphan  = err_orphan_r;
  assign err_tag_ovf = err_tag_ovf_r;
  assign err_out_ovf = err_out_ovf_r;
  assign busy        = ~tag_empty_s | (cnt_r != 2'd0);

endmodule

// File: doc/ddr3_rd_return.md
Name: ddr3_rd_return

Overview:
- Consumer end of the 36-bit command delay pipeline in the DDR3 controller.
- Takes the latency-aligned read command word and queues its tag, then collects PHY read-data beats. Each completed burst is returned with its tag to the client over a valid/ready interface.
- Sits between the command delay line output, the PHY read path and the client read port.

Parameters:
- DW, 64, width of one PHY read-data beat
- TAG_DEPTH, 4, pending-tag FIFO depth (power of two, >=2)
- OUT_DEPTH, 2, assembled-burst output buffer depth (power of two, >=2)

Ports:
- clk  in  1  controller clock
- rst_n  in  1  asynchronous active-low reset
- cmd_word  in  36  delayed command word: [35] rd, [34] bc4 (burst chop), [33:28] reserved (ignored), [27:0] tag
- phy_rd_valid  in  1  PHY read beat strobe
- phy_rd_data  in  DW  PHY read beat
- rsp_valid  out  1  burst available
- rsp_ready  in  1  client accepts burst
- rsp_data  out  4*DW  burst; beat0 in [DW-1:0], beat k in [(k+1)*DW-1:k*DW]
- rsp_tag  out  28  tag of the burst
- rsp_bc4  out  1  burst was chopped; upper 2*DW bits are zero
- err_orphan  out  1  sticky: beat arrived with no pending tag
- err_tag_ovf  out  1  sticky: rd word arrived with tag FIFO full
- err_out_ovf  out  1  sticky: burst completed with output buffer full
- busy  out  1  tag FIFO not empty or a burst is partially assembled

Behaviour:
- Reset (async assert, sync-safe deassert): all outputs 0, all pointers and counters 0, assembly register 0.
- Tag FIFO push: cmd_word[35]=1 each cycle pushes {bc4, tag}. If full, drop the word and set err_tag_ovf. cmd_word[35]=0 means no action.
- Assembly uses a beat counter 0..3 and an expected length (4, or 2 if bc4), taken from the FIFO head.
- A beat with phy_rd_valid=1 and the FIFO empty is dropped and sets err_orphan. The counter does not move.
- Otherwise the beat is written into slot[counter] and the counter increments.
- When the counter reaches the expected length, the burst completes:
  - pop the FIFO head;
  - write {data, tag, bc4} to the output buffer (unused slots zeroed);
  - reset the counter to 0.
- If the output buffer is full at completion, drop the burst and set err_out_ovf. The tag is still popped.
- Same-cycle push and pop on the tag FIFO are both permitted when it is full. The pop frees the slot, so the push succeeds and no overflow is flagged.
- A rd word pushed in cycle N is usable by a beat in cycle N+1, not in the same cycle. A beat with the FIFO empty in the same cycle as the push counts as orphan.
- Latency: final beat at edge N gives rsp_valid=1 after edge N (registered output buffer, no bypass).
- Output handshake:
  - Transfer on rsp_valid & rsp_ready.
  - rsp_data, rsp_tag and rsp_bc4 stay stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid never drops without a transfer.
  - Simultaneous pop and completion with the buffer full succeeds and raises no error.
- Pointers wrap modulo depth, using an extra MSB for full/empty.
- Sticky errors clear only on rst_n.
- Reset mid-burst discards partial data and all pending tags.
- The PHY path cannot be stalled, and the block never back-pressures it.

Decomposition:
- Shared package ddr3_pkg: cmd word bit positions (RD_BIT=35, BC4_BIT=34, TAG_MSB=27, TAG_LSB=0), TAG_W=28, BEATS_BL8=4, BEATS_BC4=2.
- One sub-module ddr3_rr_fifo (parameterised width/depth synchronous FIFO with full/empty). It is instantiated twice, for tags and for output bursts.
- Assembly counter and error logic live in the top.

Test Plan:
- Single BL8: rd word tag=0x0000123 at cycle 0, beats 0x11..,0x22..,0x33..,0x44.. at cycles 3-6 -> rsp_valid at cycle 7, rsp_data={0x44..,0x33..,0x22..,0x11..}, rsp_tag=0x123, rsp_bc4=0.
- BC4: rd word bc4=1 tag=0x5, beats A,B -> rsp_data upper 2*DW=0, low={B,A}, rsp_bc4=1. The next BL8 assembles correctly in order.
- Back-pressure: 3 back-to-back BL8 bursts with rsp_ready=0:
  - first two are held stable;
  - third sets err_out_ovf and its tag is popped;
  - raising rsp_ready delivers tags 1,2 in order.
- Orphan: beat with no pending tag -> err_orphan=1, no rsp_valid. A subsequent rd plus 4 beats returns normally.
- Tag overflow: 5 rd words on consecutive cycles with no beats -> 5th dropped, err_tag_ovf=1, busy=1. 16 beats return tags 1-4.
- Reset mid-burst: rst_n low after 2 beats -> all outputs 0 immediately. After release, a fresh BL8 returns only new data.
